load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a single-port combinational word memory.
// Handles B/H/W loads with extension, SW directly, and SB/SH as read-modify-write.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_MISALIGN  = 2'b01;
  localparam logic [1:0] ERR_RANGE     = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE, RESP
  } state_t;

  state_t              state;
  logic                is_store_q;
  logic [2:0]          funct3_q;
  logic [WORD_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   merged_q;

  logic [1:0]          err_c;
  logic [4:0]          shamt_c;
  logic [WORD_W-1:0]   lane_c;
  logic [WORD_W-1:0]   load_ext_c;
  logic [WORD_W-1:0]   mask_c;
  logic [WORD_W-1:0]   merge_c;

  // Classify the incoming request; illegal beats misaligned beats out of range.
  always_comb begin
    err_c = ERR_OK;
    if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 ||
        (req_is_store && req_funct3[2])) begin
      err_c = ERR_ILLEGAL;
    end else if (((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                 (req_funct3 == F3_W && req_addr[1:0] != 2'b00)) begin
      err_c = ERR_MISALIGN;
    end else if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) begin
      err_c = ERR_RANGE;
    end
  end

  // Lane extraction for loads; halves are aligned so a byte-granular shift works.
  always_comb begin
    shamt_c    = {addr_q[1:0], 3'b000};
    lane_c     = mem_read_data >> shamt_c;
    load_ext_c = mem_read_data;
    case (funct3_q)
      F3_B:    load_ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
      F3_H:    load_ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
      F3_BU:   load_ext_c = {24'h000000, lane_c[7:0]};
      F3_HU:   load_ext_c = {16'h0000, lane_c[15:0]};
      default: load_ext_c = mem_read_data;
    endcase
  end

  // Sub-word store merge: replace only the addressed lane of the read word.
  always_comb begin
    mask_c  = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt_c;
    merge_c = (mem_read_data & ~mask_c) | ((wdata_q << shamt_c) & mask_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      merged_q   <= '0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            if (err_c != ERR_OK) begin
              resp_err   <= err_c;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (!req_is_store) begin
              state <= LOAD;
            end else if (req_funct3 == F3_W) begin
              state <= WRITE;
            end else begin
              state <= RMW_READ;
            end
          end
        end
        LOAD: begin
          resp_rdata <= is_store_q ? '0 : load_ext_c;
          resp_err   <= ERR_OK;
          state      <= RESP;
        end
        WRITE: begin
          resp_rdata <= '0;
          resp_err   <= ERR_OK;
          state      <= RESP;
        end
        RMW_READ: begin
          merged_q <= merge_c;
          state    <= RMW_WRITE;
        end
        RMW_WRITE: begin
          resp_rdata <= '0;
          resp_err   <= ERR_OK;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign mem_read       = (state == LOAD) || (state == RMW_READ);
  assign mem_write      = (state == WRITE) || (state == RMW_WRITE);
  assign mem_address    = {addr_q[31:2], 2'b00};
  assign mem_write_data = (state == WRITE)     ? wdata_q  :
                          (state == RMW_WRITE) ? merged_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:999];
  logic [29:0] widx;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int resp_cnt = 0;
  int both_cnt = 0;

  load_store_unit #(.MEM_WORDS(1000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign widx = mem_address[31:2];
  assign mem_read_data = (widx < 30'd1000) ? mem[widx[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write && widx < 30'd1000) mem[widx[9:0]] = mem_write_data;
  end

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (resp_valid) resp_cnt++;
    if (mem_read && mem_write) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge, let it be accepted, then scramble the inputs.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid    = 1'b0;
    req_is_store = ~st;
    req_funct3   = 3'b111;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = 32'h5A5A_5A5A;
  endtask

  // Cycles after acceptance until resp_valid; -1 on timeout. Leaves us in the RESP cycle.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      if (resp_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  int lat;
  int rd0, wr0, rs0;
  int acc [0:2];
  logic [31:0] got [0:2];
  int k, r;
  logic adv;
  logic [31:0] lw_addr [0:2];

  initial begin
    for (int i = 0; i < 1000; i++) mem[i] = 32'h0;
    mem[4]  = 32'h8BAD_F00D;
    mem[8]  = 32'h1122_3344;
    mem[16] = 32'hCAFE_BABE;
    mem[24] = 32'hA000_0001;
    mem[25] = 32'hB000_0002;
    mem[26] = 32'hC000_0003;
    lw_addr[0] = 32'h60; lw_addr[1] = 32'h64; lw_addr[2] = 32'h68;

    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Loads with sign/zero extension
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    check("lb_ready_busy", 32'(req_ready), 32'd0);
    check("lb_mem_read", 32'(mem_read), 32'd1);
    check("lb_mem_address", mem_address, 32'h10);
    wait_resp(lat);
    check("lb_latency", 32'(lat), 32'd2);
    check("lb_rdata", resp_rdata, 32'hFFFF_FF8B);
    check("lb_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    check("lb_rdata_hold", resp_rdata, 32'hFFFF_FF8B);

    issue(1'b0, 3'b100, 32'h13, 32'h0);
    wait_resp(lat);
    check("lbu_latency", 32'(lat), 32'd2);
    check("lbu_rdata", resp_rdata, 32'h0000_008B);
    @(negedge clk);
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    wait_resp(lat);
    check("lh_rdata", resp_rdata, 32'hFFFF_8BAD);
    @(negedge clk);
    issue(1'b0, 3'b101, 32'h10, 32'h0);
    wait_resp(lat);
    check("lhu_rdata", resp_rdata, 32'h0000_F00D);
    @(negedge clk);

    // SB via read-modify-write
    issue(1'b1, 3'b000, 32'h21, 32'h0000_00AA);
    check("sb_rmw_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    check("sb_mem_write", 32'(mem_write), 32'd1);
    check("sb_mem_read_low", 32'(mem_read), 32'd0);
    check("sb_merged", mem_write_data, 32'h1122_AA44);
    @(negedge clk);
    check("sb_resp_valid", 32'(resp_valid), 32'd1);
    check("sb_err", 32'(resp_err), 32'd0);
    check("sb_rdata", resp_rdata, 32'h0);
    check("sb_mem_word", mem[8], 32'h1122_AA44);
    @(negedge clk);

    issue(1'b1, 3'b001, 32'h22, 32'h0000_5566);
    wait_resp(lat);
    check("sh_latency", 32'(lat), 32'd3);
    check("sh_mem_word", mem[8], 32'h5566_AA44);
    @(negedge clk);

    issue(1'b1, 3'b010, 32'h30, 32'hDEAD_BEEF);
    check("sw_mem_write", 32'(mem_write), 32'd1);
    check("sw_wdata", mem_write_data, 32'hDEAD_BEEF);
    wait_resp(lat);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_mem_word", mem[12], 32'hDEAD_BEEF);
    @(negedge clk);

    // Error classes: no memory access, response one cycle after accept
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b0, 3'b010, 32'h06, 32'h0);
    wait_resp(lat);
    check("lw_mis_latency", 32'(lat), 32'd1);
    check("lw_mis_err", 32'(resp_err), 32'd1);
    check("lw_mis_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    issue(1'b1, 3'b010, 32'hFA0, 32'h1234_5678);
    wait_resp(lat);
    check("sw_range_latency", 32'(lat), 32'd1);
    check("sw_range_err", 32'(resp_err), 32'd2);
    @(negedge clk);
    issue(1'b0, 3'b001, 32'h1001, 32'h0);
    wait_resp(lat);
    check("mis_over_range_err", 32'(resp_err), 32'd1);
    @(negedge clk);
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    wait_resp(lat);
    check("f3_011_err", 32'(resp_err), 32'd3);
    @(negedge clk);
    issue(1'b1, 3'b100, 32'h10, 32'h0);
    wait_resp(lat);
    check("store_bu_err", 32'(resp_err), 32'd3);
    @(negedge clk);
    issue(1'b1, 3'b101, 32'h11, 32'h0);
    wait_resp(lat);
    check("illegal_over_mis_err", 32'(resp_err), 32'd3);
    @(negedge clk);
    check("err_no_mem_read", 32'(rd_cnt - rd0), 32'd0);
    check("err_no_mem_write", 32'(wr_cnt - wr0), 32'd0);

    // Reset in the middle of an SH read-modify-write
    wr0 = wr_cnt; rs0 = resp_cnt;
    issue(1'b1, 3'b001, 32'h40, 32'h0000_1234);
    check("rst_rmw_read_active", 32'(mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_mem_read", 32'(mem_read), 32'd0);
    check("rst_async_ready", 32'(req_ready), 32'd1);
    check("rst_async_address", mem_address, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("rst_no_resp", 32'(resp_cnt - rs0), 32'd0);
    check("rst_word_kept", mem[16], 32'hCAFE_BABE);
    check("rst_release_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    wait_resp(lat);
    check("post_rst_latency", 32'(lat), 32'd2);
    check("post_rst_rdata", resp_rdata, 32'hCAFE_BABE);
    @(negedge clk);

    // Three LW requests with req_valid held high
    rs0 = resp_cnt; k = 0; r = 0; adv = 1'b0;
    for (int i = 0; i < 3; i++) begin acc[i] = -1; got[i] = '0; end
    for (int n = 0; n < 14; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0) begin
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_addr = lw_addr[0]; req_wdata = '0;
      end
      if (adv) begin
        if (k < 3) req_addr = lw_addr[k];
        else req_valid = 1'b0;
        adv = 1'b0;
      end
      if (resp_valid && r < 3) begin
        got[r] = resp_rdata;
        r++;
      end
      if (req_valid && req_ready && k < 3) begin
        acc[k] = n;
        k++;
        adv = 1'b1;
      end
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(k), 32'd3);
    check("b2b_gap_01", 32'(acc[1] - acc[0]), 32'd3);
    check("b2b_gap_12", 32'(acc[2] - acc[1]), 32'd3);
    check("b2b_resp_pulses", 32'(resp_cnt - rs0), 32'd3);
    check("b2b_rdata0", got[0], 32'hA000_0001);
    check("b2b_rdata1", got[1], 32'hB000_0002);
    check("b2b_rdata2", got[2], 32'hC000_0003);
    check("never_read_and_write", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
